// File: rtl/hp_tube_pkg.sv
// rtl/hp_tube_pkg.sv - shared constants and count encoding for the parasite register-3 FIFO
//
// Purpose : default FIFO geometry, occupancy encoding and the occupancy
//           step helper used by hp_reg3_fifo_m.
// Ports   : none (package).
package hp_tube_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_e;

  // Next occupancy for an accepted push and/or pop. Callers only pass an
  // accepted push/pop, so the count never steps past FULL or below EMPTY.
  function automatic cnt_e cnt_step(cnt_e c, logic up, logic dn);
    cnt_e n;
    n = c;
    if (up && !dn) begin
      if (c == EMPTY) n = ONE;
      else            n = FULL;
    end else if (dn && !up) begin
      if (c == FULL) n = ONE;
      else           n = EMPTY;
    end
    return n;
  endfunction

endpackage

// File: rtl/hp_fifo_store_m.sv
// rtl/hp_fifo_store_m.sv - two-entry FIFO storage with head/tail pointers
//
// Purpose : holds the FIFO entries and the head/tail pointers; the caller
//           only issues pushes and pops it has already accepted.
// Ports   : i_clk        clock (rising edge)
//           i_rst_b      asynchronous active-low reset of the pointers
//           i_clr        synchronous pointer flush
//           i_push       write i_wr_data at the tail, advance tail
//           i_pop        advance head
//           i_wr_data    entry to write
//           o_head_data  entry at the head
module hp_fifo_store_m
  import hp_tube_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_b,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_clr) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
    end
  end

  // Contents need no reset: occupancy in the top decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) r_mem[r_tail] <= i_wr_data;
  end

  assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/hp_reg3_fifo_m.sv
// rtl/hp_reg3_fifo_m.sv - host-to-parasite register-3 FIFO (one- or two-byte mode)
//
// Purpose : host pushes bytes, parasite pops them on the first cycle of a
//           register-3 read; flags follow occupancy and the two_byte mode.
// Config  : define HP_REG3_NMI_EN to drive nmi from p2_data_available;
//           otherwise nmi is tied low.
// Ports   : p2_clk             clock (rising edge)
//           rst_b              asynchronous active-low reset
//           wr_stb / wr_data   host write pulse and byte
//           p2_select/p2_rdnw  parasite register-3 access (read when rdnw=1)
//           two_byte           0 = one-byte FIFO, 1 = two-byte FIFO
//           clr                synchronous flush
//           rd_data            registered head entry
//           p2_data_available  parasite may read
//           host_full          host must not write
//           overrun            sticky: a host write was dropped
//           nmi                parasite interrupt request
module hp_reg3_fifo_m
  import hp_tube_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              p2_clk,
  input  logic              rst_b,
  input  logic              wr_stb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              p2_select,
  input  logic              p2_rdnw,
  input  logic              two_byte,
  input  logic              clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              p2_data_available,
  output logic              host_full,
  output logic              overrun,
  output logic              nmi
);

  cnt_e              r_count;
  cnt_e              w_count_nxt;
  logic              r_rd_prev;
  logic              r_overrun;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] w_head_data;
  logic              w_rd_acc;
  logic              w_rd_first;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_load;

  assign w_rd_acc   = p2_select & p2_rdnw;
  assign w_rd_first = w_rd_acc & ~r_rd_prev;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees the head slot on the same edge.
  assign w_pop  = w_rd_first & (r_count != EMPTY) & ~clr;
  assign w_push = wr_stb & ((r_count != FULL) | w_pop) & ~clr;
  assign w_drop = wr_stb & (r_count == FULL) & ~w_pop & ~clr;

  // rd_data is frozen while a read access is in progress so the parasite
  // sees one stable byte; the new head is latched once the access ends.
  // With no access there is no pop, so the head only changes when an
  // empty FIFO takes a push (forward wr_data for that case).
  assign w_load = ~clr & ~w_rd_acc & ((r_count != EMPTY) | w_push);

  assign w_count_nxt = cnt_step(r_count, w_push, w_pop);

  always_ff @(posedge p2_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count   <= EMPTY;
      r_rd_prev <= 1'b0;
      r_overrun <= 1'b0;
      r_rd_data <= '0;
    end else if (clr) begin
      r_count   <= EMPTY;
      r_rd_prev <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_rd_prev <= w_rd_acc;
      if (w_drop) r_overrun <= 1'b1;
      if (w_load) r_rd_data <= (r_count == EMPTY) ? wr_data : w_head_data;
    end
  end

  hp_fifo_store_m #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .i_clk       (p2_clk),
    .i_rst_b     (rst_b),
    .i_clr       (clr),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wr_data   (wr_data),
    .o_head_data (w_head_data)
  );

  assign rd_data           = r_rd_data;
  assign overrun           = r_overrun;
  assign p2_data_available = two_byte ? (r_count == FULL) : (r_count != EMPTY);
  assign host_full         = two_byte ? (r_count == FULL) : (r_count != EMPTY);

`ifdef HP_REG3_NMI_EN
  assign nmi = p2_data_available;
`else
  assign nmi = 1'b0;
`endif

endmodule

// File: tb/tb_hp_reg3_fifo_m.sv
// tb/tb_hp_reg3_fifo_m.sv - self-checking bench for hp_reg3_fifo_m
module tb_hp_reg3_fifo_m;

  logic       p2_clk = 1'b0;
  logic       rst_b;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       p2_select;
  logic       p2_rdnw;
  logic       two_byte;
  logic       clr;
  logic [7:0] rd_data;
  logic       p2_data_available;
  logic       host_full;
  logic       overrun;
  logic       nmi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 p2_clk = ~p2_clk;

  hp_reg3_fifo_m #(.DATA_W(8), .DEPTH(2)) dut (
    .p2_clk            (p2_clk),
    .rst_b             (rst_b),
    .wr_stb            (wr_stb),
    .wr_data           (wr_data),
    .p2_select         (p2_select),
    .p2_rdnw           (p2_rdnw),
    .two_byte          (two_byte),
    .clr               (clr),
    .rd_data           (rd_data),
    .p2_data_available (p2_data_available),
    .host_full         (host_full),
    .overrun           (overrun),
    .nmi               (nmi)
  );

  typedef struct {
    logic       stb;
    logic [7:0] d;
    logic       sel;
    logic       rdnw;
    logic       tb;
    logic       clr;
    logic [7:0] e_rd;
    logic       e_av;
    logic       e_full;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic exp_nmi(logic av);
`ifdef HP_REG3_NMI_EN
    return av;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [7:0] rd, logic av, logic full, logic ovr);
    chk({tag, " rd_data"}, rd_data, rd);
    chk({tag, " avail"},   {7'd0, p2_data_available}, {7'd0, av});
    chk({tag, " full"},    {7'd0, host_full}, {7'd0, full});
    chk({tag, " overrun"}, {7'd0, overrun}, {7'd0, ovr});
    chk({tag, " nmi"},     {7'd0, nmi}, {7'd0, exp_nmi(av)});
  endtask

  task automatic drive(logic stb, logic [7:0] d, logic sel, logic rdnw, logic tb, logic c);
    wr_stb = stb; wr_data = d; p2_select = sel; p2_rdnw = rdnw; two_byte = tb; clr = c;
  endtask

  task automatic step();
    @(posedge p2_clk);
    #1;
  endtask

  //      stb  d      sel rdnw tb  clr   rd     av   full ovr
  function automatic void v(logic stb, logic [7:0] d, logic sel, logic rdnw, logic tb,
                            logic c, logic [7:0] rd, logic av, logic full, logic ovr);
    vecs.push_back('{stb, d, sel, rdnw, tb, c, rd, av, full, ovr});
  endfunction

  initial begin
    rst_b = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    #2;
    chk_all("reset", 8'h00, 0, 0, 0);
    @(posedge p2_clk);
    @(posedge p2_clk);
    #3 rst_b = 1'b1;
    #1;
    chk_all("post_reset", 8'h00, 0, 0, 0);

    // one-byte mode, 3-cycle read of 0x5A
    v(1, 8'h5A, 0, 0, 0, 0, 8'h5A, 1, 1, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h5A, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'h5A, 0, 0, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'h5A, 0, 0, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'h5A, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h5A, 0, 0, 0);
    // two-byte mode, 0x11 then 0x22
    v(1, 8'h11, 0, 0, 1, 0, 8'h11, 0, 0, 0);
    v(1, 8'h22, 0, 0, 1, 0, 8'h11, 1, 1, 0);
    v(0, 8'h00, 1, 1, 1, 0, 8'h11, 0, 0, 0);
    v(0, 8'h00, 0, 0, 1, 0, 8'h22, 0, 0, 0);
    v(0, 8'h00, 1, 1, 1, 0, 8'h22, 0, 0, 0);
    v(0, 8'h00, 0, 0, 1, 0, 8'h22, 0, 0, 0);
    // overrun: 0x33 dropped, originals survive, clr wins over push
    v(1, 8'hA1, 0, 0, 1, 0, 8'hA1, 0, 0, 0);
    v(1, 8'hA2, 0, 0, 1, 0, 8'hA1, 1, 1, 0);
    v(1, 8'h33, 0, 0, 1, 0, 8'hA1, 1, 1, 1);
    v(0, 8'h00, 1, 1, 1, 0, 8'hA1, 0, 0, 1);
    v(0, 8'h00, 0, 0, 1, 0, 8'hA2, 0, 0, 1);
    v(0, 8'h00, 1, 1, 1, 0, 8'hA2, 0, 0, 1);
    v(0, 8'h00, 0, 0, 1, 0, 8'hA2, 0, 0, 1);
    v(1, 8'hB1, 0, 0, 1, 0, 8'hB1, 0, 0, 1);
    v(1, 8'hC5, 0, 0, 1, 1, 8'hB1, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'hB1, 0, 0, 0);
    // push and pop on the same edge with count=1
    v(1, 8'h44, 0, 0, 0, 0, 8'h44, 1, 1, 0);
    v(1, 8'h55, 1, 1, 0, 0, 8'h44, 1, 1, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h55, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'h55, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h55, 0, 0, 0);
    // two_byte toggled mid-operation: flags only
    v(1, 8'h77, 0, 0, 1, 0, 8'h77, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h77, 1, 1, 0);
    v(0, 8'h00, 0, 0, 1, 0, 8'h77, 0, 0, 0);
    v(0, 8'h00, 1, 1, 1, 0, 8'h77, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h77, 0, 0, 0);
    // parasite write ignored, pop on empty ignored
    v(1, 8'h88, 0, 0, 0, 0, 8'h88, 1, 1, 0);
    v(0, 8'h00, 1, 0, 0, 0, 8'h88, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'h88, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h88, 0, 0, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'h88, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'h88, 0, 0, 0);
    // held select with count=2 pops exactly once
    v(1, 8'hC1, 0, 0, 0, 0, 8'hC1, 1, 1, 0);
    v(1, 8'hC2, 0, 0, 0, 0, 8'hC1, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'hC1, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'hC1, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'hC1, 1, 1, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'hC2, 1, 1, 0);
    v(0, 8'h00, 1, 1, 0, 0, 8'hC2, 0, 0, 0);
    v(0, 8'h00, 0, 0, 0, 0, 8'hC2, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stb, vecs[i].d, vecs[i].sel, vecs[i].rdnw, vecs[i].tb, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_av, vecs[i].e_full, vecs[i].e_ovr);
    end

    // reset mid-read with count=2, select held through release
    drive(1, 8'hD1, 0, 0, 1, 0); step();
    drive(1, 8'hD2, 0, 0, 1, 0); step();
    chk_all("rst_pre", 8'hD1, 1, 1, 0);
    drive(0, 8'h00, 1, 1, 1, 0);
    #3 rst_b = 1'b0;
    #1;
    chk_all("rst_mid", 8'h00, 0, 0, 0);
    @(posedge p2_clk);
    @(posedge p2_clk);
    #3 rst_b = 1'b1;
    two_byte = 1'b0;
    step();
    chk_all("rst_hold1", 8'h00, 0, 0, 0);
    step();
    chk_all("rst_hold2", 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0, 0); step();
    chk_all("rst_rel", 8'h00, 0, 0, 0);
    drive(1, 8'hE1, 0, 0, 0, 0); step();
    chk_all("rst_push", 8'hE1, 1, 1, 0);
    drive(0, 8'h00, 1, 1, 0, 0); step();
    drive(0, 8'h00, 0, 0, 0, 0); step();
    chk_all("rst_drain", 8'hE1, 0, 0, 0);

    // nmi in one-byte mode
    drive(1, 8'h66, 0, 0, 0, 0); step();
    drive(0, 8'h00, 0, 0, 0, 0);
    chk("nmi_66", {7'd0, nmi}, {7'd0, exp_nmi(1'b1)});
    chk("nmi_66 rd", rd_data, 8'h66);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
